// File: rtl/conv_pkg.sv
// Shared widths and defaults for the conv core accumulate stage, plus a constant-foldable clog2.
package conv_pkg;

    localparam int PROD_WIDTH     = 22;
    localparam int KERNEL_LEN_DEF = 9;
    localparam int OUT_WIDTH_DEF  = 24;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_sat_unsigned.sv
// Unsigned clip of an IN_WIDTH value to OUT_WIDTH with a clipped flag.
// Purely combinational, zero latency, no flow control.
module conv_sat_unsigned #(
    parameter int IN_WIDTH  = 26,
    parameter int OUT_WIDTH = 24
) (
    input  logic [IN_WIDTH-1:0]  i_val,
    output logic [OUT_WIDTH-1:0] o_val,
    output logic                 o_sat
);

    generate
        if (IN_WIDTH > OUT_WIDTH) begin : g_clip
            logic w_over;
            assign w_over = |i_val[IN_WIDTH-1:OUT_WIDTH];
            assign o_sat  = w_over;
            assign o_val  = w_over ? {OUT_WIDTH{1'b1}} : i_val[OUT_WIDTH-1:0];
        end else begin : g_pass
            // Output is at least as wide as the input, so nothing can clip.
            assign o_sat = 1'b0;
            assign o_val = OUT_WIDTH'(i_val);
        end
    endgenerate

endmodule

// File: rtl/conv_mac_accum.sv
// Sums KERNEL_LEN-product windows into a saturated result held in a one-entry output register.
// Result valid one cycle after the closing beat; only the closing beat stalls on a full output.
module conv_mac_accum
    import conv_pkg::*;
#(
    parameter int KERNEL_LEN = KERNEL_LEN_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] in_prod,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_framing,
    input  logic                  err_clr,
    output logic [15:0]           group_cnt
);

    localparam int ACC_WIDTH = PROD_WIDTH + clog2(KERNEL_LEN);
    localparam int CNT_WIDTH = (clog2(KERNEL_LEN) > 0) ? clog2(KERNEL_LEN) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(KERNEL_LEN - 1);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic                 r_out_sat;
    logic                 r_out_valid;
    logic                 r_err;
    logic [15:0]          r_grp;

    logic                 w_last_beat;
    logic                 w_accept;
    logic [ACC_WIDTH-1:0] w_sum;
    logic [OUT_WIDTH-1:0] w_sat_data;
    logic                 w_sat_flag;

    assign w_last_beat = (r_cnt == LAST_CNT);
    assign in_ready    = !w_last_beat || !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    // First beat of a window restarts the sum instead of adding to stale acc.
    assign w_sum       = (r_cnt == '0) ? ACC_WIDTH'(in_prod)
                                       : r_acc + ACC_WIDTH'(in_prod);

    conv_sat_unsigned #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat (
        .i_val (w_sum),
        .o_val (w_sat_data),
        .o_sat (w_sat_flag)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_grp       <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= w_sum;
                if (w_last_beat) begin
                    r_cnt      <= '0;
                    r_out_data <= w_sat_data;
                    r_out_sat  <= w_sat_flag;
                    r_grp      <= r_grp + 16'd1;
                end else begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end

            // A new load takes priority over the consumer draining the register.
            if (w_accept && w_last_beat) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept && (in_last != w_last_beat)) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_sat     = r_out_sat;
    assign out_valid   = r_out_valid;
    assign err_framing = r_err;
    assign group_cnt   = r_grp;

endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed bench for conv_mac_accum: window table plus backpressure, reset and KERNEL_LEN=1 sequences.
module tb_conv_mac_accum;

    logic        ap_clk;
    logic        ap_rst;

    logic [21:0] in_prod;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [23:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic        err_framing;
    logic        err_clr;
    logic [15:0] group_cnt;

    logic [21:0] b_prod;
    logic        b_valid;
    logic        b_ready;
    logic        b_last;
    logic [23:0] b_data;
    logic        b_sat;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_err;
    logic        b_err_clr;
    logic [15:0] b_grp;

    int n_vec = 0;
    int n_err = 0;
    int exp_grp = 0;

    conv_mac_accum dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .in_prod     (in_prod),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_framing (err_framing),
        .err_clr     (err_clr),
        .group_cnt   (group_cnt)
    );

    conv_mac_accum #(.KERNEL_LEN(1), .OUT_WIDTH(24)) dut_k1 (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .in_prod     (b_prod),
        .in_valid    (b_valid),
        .in_ready    (b_ready),
        .in_last     (b_last),
        .out_data    (b_data),
        .out_sat     (b_sat),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .err_framing (b_err),
        .err_clr     (b_err_clr),
        .group_cnt   (b_grp)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [21:0] base;
        logic [21:0] step;
        logic [21:0] extra;
        logic [8:0]  last_mask;
        logic [23:0] exp_data;
        logic        exp_sat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic [21:0] p, input logic l);
        int waited;
        waited = 0;
        @(negedge ap_clk);
        in_prod  = p;
        in_valid = 1'b1;
        in_last  = l;
        while (!in_ready && waited < 50) begin
            @(negedge ap_clk);
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge ap_clk);
        err_clr = 1'b1;
        @(posedge ap_clk);
        #1;
        err_clr = 1'b0;
        chk("err_clr", 32'(err_framing), 32'd0);
    endtask

    initial begin
        ap_rst      = 1'b1;
        in_prod     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        err_clr     = 1'b0;
        b_prod      = '0;
        b_valid     = 1'b0;
        b_last      = 1'b0;
        b_out_ready = 1'b1;
        b_err_clr   = 1'b0;

        vecs[0] = '{22'd1,       22'd1, 22'd0, 9'h100, 24'd45,       1'b0, 1'b0};
        vecs[1] = '{22'd4177665, 22'd0, 22'd0, 9'h100, 24'd16777215, 1'b1, 1'b0};
        vecs[2] = '{22'd1864135, 22'd0, 22'd0, 9'h100, 24'd16777215, 1'b0, 1'b0};
        vecs[3] = '{22'd1864135, 22'd0, 22'd1, 9'h100, 24'd16777215, 1'b1, 1'b0};
        vecs[4] = '{22'd0,       22'd0, 22'd0, 9'h100, 24'd0,        1'b0, 1'b0};
        vecs[5] = '{22'd4194303, 22'd0, 22'd0, 9'h100, 24'd16777215, 1'b1, 1'b0};
        vecs[6] = '{22'd1,       22'd1, 22'd0, 9'h010, 24'd45,       1'b0, 1'b1};

        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_err", 32'(err_framing), 32'd0);
        chk("rst_group_cnt", 32'(group_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 9; k++) begin
                beat(vecs[i].base + vecs[i].step * 22'(k) + ((k == 8) ? vecs[i].extra : 22'd0),
                     vecs[i].last_mask[k]);
            end
            exp_grp++;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_sat", i), 32'(out_sat), 32'(vecs[i].exp_sat));
            chk($sformatf("vec%0d_err", i), 32'(err_framing), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_grp", i), 32'(group_cnt), 32'(exp_grp));
            if (vecs[i].exp_err) begin
                @(posedge ap_clk);
                #1;
                chk("err_sticky", 32'(err_framing), 32'd1);
                chk("drain_valid", 32'(out_valid), 32'd0);
                clear_err();
            end
        end

        // Error and clear in the same cycle: the error must win.
        err_clr = 1'b1;
        beat(22'd3, 1'b1);
        err_clr = 1'b0;
        chk("err_wins", 32'(err_framing), 32'd1);
        for (int k = 0; k < 8; k++) beat(22'd1, (k == 7));
        exp_grp++;
        chk("errwin_data", 32'(out_data), 32'd11);
        chk("errwin_grp", 32'(group_cnt), 32'(exp_grp));
        clear_err();

        // Backpressure: closing beat of window 2 stalls until the held 45 drains.
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) beat(22'(k + 1), (k == 8));
        exp_grp++;
        chk("bp_w1_data", 32'(out_data), 32'd45);
        for (int k = 0; k < 8; k++) beat(22'd2, 1'b0);
        @(negedge ap_clk);
        in_prod  = 22'd2;
        in_valid = 1'b1;
        in_last  = 1'b1;
        #1;
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge ap_clk);
        chk("bp_stall_ready2", 32'(in_ready), 32'd0);
        chk("bp_hold_data", 32'(out_data), 32'd45);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_grp++;
        chk("bp_w2_valid", 32'(out_valid), 32'd1);
        chk("bp_w2_data", 32'(out_data), 32'd18);
        chk("bp_w2_grp", 32'(group_cnt), 32'(exp_grp));
        @(posedge ap_clk);
        #1;
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset mid-window with a held result pending.
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) beat(22'(k + 1), (k == 8));
        for (int k = 0; k < 4; k++) beat(22'd100, 1'b0);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #2;
        ap_rst = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_grp", 32'(group_cnt), 32'd0);
        chk("mrst_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) beat(22'd2, (k == 8));
        chk("mrst_w_data", 32'(out_data), 32'd18);
        chk("mrst_w_grp", 32'(group_cnt), 32'd1);
        chk("mrst_w_err", 32'(err_framing), 32'd0);

        // KERNEL_LEN=1: every beat closes a window.
        @(negedge ap_clk);
        b_prod  = 22'd7;
        b_valid = 1'b1;
        b_last  = 1'b1;
        #1;
        chk("k1_ready0", 32'(b_ready), 32'd1);
        @(posedge ap_clk);
        #1;
        chk("k1_data7", 32'(b_data), 32'd7);
        chk("k1_valid7", 32'(b_out_valid), 32'd1);
        b_prod = 22'd9;
        chk("k1_ready1", 32'(b_ready), 32'd1);
        @(posedge ap_clk);
        #1;
        b_valid = 1'b0;
        chk("k1_data9", 32'(b_data), 32'd9);
        chk("k1_valid9", 32'(b_out_valid), 32'd1);
        chk("k1_sat", 32'(b_sat), 32'd0);
        chk("k1_grp", 32'(b_grp), 32'd2);
        chk("k1_err", 32'(b_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
